// File: rtl/max_reduce_seq_if.sv
// Operand/config/result handshake bundle for max_reduce_seq.
// slave modport is the reducer side; master is the driving environment.
interface max_reduce_seq_if #(
    parameter int W  = 32,
    parameter int LW = 16
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [LW-1:0] cfg_len;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_max;
    logic [LW-1:0] out_idx;
    logic          out_empty;

    modport slave (
        input  cfg_valid, cfg_len, abort, in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_max, out_idx, out_empty
    );

    modport master (
        output cfg_valid, cfg_len, abort, in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_max, out_idx, out_empty
    );
endinterface

// File: rtl/max_reduce_seq.sv
// Sequential max/argmax over a configured-length frame, one operand per cycle.
// Result valid the cycle after the last operand; held until out_ready or abort.
module max_reduce_seq #(
    parameter int W  = 32,
    parameter int LW = 16
) (
    input  logic           clk,
    input  logic           rst,
    max_reduce_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [W-1:0]  max_q, max_d;
    logic          out_valid_q, out_valid_d;
    logic          empty_q, empty_d;

    logic          take_new;
    logic [W-1:0]  sel_word;

    // Shared compare/select: first operand of a frame always wins, later ones only on strict >.
    assign take_new = (count_q == '0) || (bus.in_data > max_q);
    assign sel_word = take_new ? bus.in_data : max_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        idx_d       = idx_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        empty_d     = empty_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid && !bus.abort) begin
                    if (bus.cfg_len != '0) begin
                        len_d   = bus.cfg_len;
                        count_d = '0;
                        state_d = ACCUM;
                    end else begin
                        max_d       = '0;
                        idx_d       = '0;
                        empty_d     = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            ACCUM: begin
                if (bus.abort) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (bus.in_valid) begin
                    max_d   = sel_word;
                    idx_d   = take_new ? count_q : idx_q;
                    count_d = count_q + LW'(1);
                    if (count_q == len_q - LW'(1)) begin
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                // abort and delivery both end the result; abort simply wins the tie.
                if (bus.abort || bus.out_ready) begin
                    out_valid_d = 1'b0;
                    empty_d     = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                empty_d     = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            empty_q     <= empty_d;
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_max   = max_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_empty = empty_q;
endmodule

// File: tb/tb_max_reduce_seq.sv
// Directed and randomized checks of max_reduce_seq against an array-scan max/argmax model.
module tb_max_reduce_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] ops[$];
    int   hs_cnt;

    max_reduce_seq_if #(.W(32), .LW(16)) bus ();
    max_reduce_seq #(.W(32), .LW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 400000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index of the strict maximum, scanning the operand list.
    task automatic model(input int len, output logic [31:0] m, output logic [15:0] idx, output logic empty);
        m = 32'd0; idx = 16'd0; empty = (len == 0);
        for (int i = 0; i < len; i++) begin
            if (i == 0 || ops[i] > m) begin
                m   = ops[i];
                idx = 16'(i);
            end
        end
    endtask

    task automatic run_frame(input int len, input int gap_mode, output int cycles, output bit tmo);
        int n;
        hs_cnt = 0; cycles = 0; tmo = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = len[15:0];
        tick(); cycles++;
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (gap_mode == 1 && i > 0) begin
                bus.in_valid = 1'b0; tick(); cycles++;
            end
            if (gap_mode == 2) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0; tick(); cycles++;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = ops[i];
            if (bus.in_ready) hs_cnt++;
            tick(); cycles++;
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick(); n++; cycles++;
        end
        tmo = !bus.out_valid;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.cfg_valid = 0; bus.cfg_len = 0; bus.abort = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_empty} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl: cfg_rdy/in_rdy/out_vld/empty=%b required 1000",
                {bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_empty});
        end
        vectors++;
        if (bus.out_max !== 32'd0 || bus.out_idx !== 16'd0) begin
            errors++; $display("FAIL reset_data: max=%h idx=%0d required 0/0", bus.out_max, bus.out_idx);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.cfg_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: cfg_rdy=%b out_vld=%b required 1/0", bus.cfg_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        int cyc; bit tmo;
        ops = '{32'd5, 32'd9, 32'd3, 32'd9};
        run_frame(4, 0, cyc, tmo);
        vectors++;
        if (tmo !== 1'b0 || cyc != 5) begin
            errors++; $display("FAIL basic_latency: cycles=%0d timeout=%b required 5/0", cyc, tmo);
        end
        vectors++;
        if (bus.out_max !== 32'd9 || bus.out_idx !== 16'd1 || bus.out_empty !== 1'b0) begin
            errors++; $display("FAIL basic_result: max=%0d idx=%0d empty=%b required 9/1/0",
                bus.out_max, bus.out_idx, bus.out_empty);
        end
        consume();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL basic_release: out_vld=%b cfg_rdy=%b required 0/1", bus.out_valid, bus.cfg_ready);
        end
    endtask

    task automatic test_empty();
        int cyc; bit tmo;
        run_frame(0, 0, cyc, tmo);
        vectors++;
        if (tmo !== 1'b0 || cyc != 1) begin
            errors++; $display("FAIL empty_latency: cycles=%0d timeout=%b required 1/0", cyc, tmo);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_empty !== 1'b1 || bus.out_max !== 32'd0 || bus.out_idx !== 16'd0) begin
                errors++; $display("FAIL empty_hold%0d: vld=%b empty=%b max=%h idx=%0d required 1/1/0/0",
                    k, bus.out_valid, bus.out_empty, bus.out_max, bus.out_idx);
            end
            tick();
        end
        consume();
        vectors++;
        if (bus.cfg_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_empty !== 1'b0) begin
            errors++; $display("FAIL empty_release: cfg_rdy=%b vld=%b empty=%b required 1/0/0",
                bus.cfg_ready, bus.out_valid, bus.out_empty);
        end
    endtask

    task automatic test_unsigned();
        int cyc; bit tmo;
        ops = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        run_frame(3, 1, cyc, tmo);
        vectors++;
        if (tmo !== 1'b0 || hs_cnt != 3) begin
            errors++; $display("FAIL unsigned_hs: handshakes=%0d timeout=%b required 3/0", hs_cnt, tmo);
        end
        bus.in_valid = 1'b1; bus.in_data = 32'h1234;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL unsigned_in_rdy_done: in_rdy=%b required 0", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_max !== 32'hFFFF_FFFF || bus.out_idx !== 16'd0) begin
            errors++; $display("FAIL unsigned_result: max=%h idx=%0d required ffffffff/0", bus.out_max, bus.out_idx);
        end
        consume();
    endtask

    task automatic test_done_cfg_ignored();
        int cyc; bit tmo;
        ops = '{32'd7};
        run_frame(1, 0, cyc, tmo);
        bus.cfg_valid = 1'b1; bus.cfg_len = 16'd3;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (bus.cfg_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL done_cfg%0d: cfg_rdy=%b vld=%b required 0/1", k, bus.cfg_ready, bus.out_valid);
            end
            tick();
        end
        bus.cfg_valid = 1'b0;
        vectors++;
        if (tmo !== 1'b0 || bus.out_max !== 32'd7 || bus.out_idx !== 16'd0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL done_result: max=%0d idx=%0d vld=%b tmo=%b required 7/0/1/0",
                bus.out_max, bus.out_idx, bus.out_valid, tmo);
        end
        consume();
    endtask

    task automatic test_abort();
        int cyc; bit tmo;
        bus.cfg_valid = 1'b1; bus.cfg_len = 16'd5;
        tick();
        bus.cfg_valid = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'd11; tick();
        bus.in_data = 32'd22; tick();
        bus.in_data = 32'd33; bus.abort = 1'b1; tick();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL abort_accum: vld=%b cfg_rdy=%b in_rdy=%b required 0/1/0",
                bus.out_valid, bus.cfg_ready, bus.in_ready);
        end
        tick(); tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_result: vld=%b required 0", bus.out_valid);
        end
        ops = '{32'd1, 32'd2};
        run_frame(2, 0, cyc, tmo);
        vectors++;
        if (tmo !== 1'b0 || bus.out_max !== 32'd2 || bus.out_idx !== 16'd1) begin
            errors++; $display("FAIL abort_next_frame: max=%0d idx=%0d tmo=%b required 2/1/0", bus.out_max, bus.out_idx, tmo);
        end
        bus.abort = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.abort = 1'b0; bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL abort_done: vld=%b cfg_rdy=%b required 0/1", bus.out_valid, bus.cfg_ready);
        end
    endtask

    task automatic test_async_reset();
        int cyc; bit tmo;
        bus.cfg_valid = 1'b1; bus.cfg_len = 16'd4;
        tick();
        bus.cfg_valid = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'd100; tick();
        bus.in_data = 32'd200; tick();
        bus.in_data = 32'd3;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_empty} !== 4'b1000 ||
            bus.out_max !== 32'd0 || bus.out_idx !== 16'd0) begin
            errors++; $display("FAIL async_reset: rdy/in/vld/empty=%b max=%0d idx=%0d required 1000/0/0",
                {bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_empty}, bus.out_max, bus.out_idx);
        end
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        ops = '{32'd10, 32'd4};
        run_frame(2, 0, cyc, tmo);
        vectors++;
        if (tmo !== 1'b0 || bus.out_max !== 32'd10 || bus.out_idx !== 16'd0) begin
            errors++; $display("FAIL async_next_frame: max=%0d idx=%0d tmo=%b required 10/0/0", bus.out_max, bus.out_idx, tmo);
        end
        consume();
    endtask

    task automatic test_random();
        int cyc; bit tmo; int len;
        logic [31:0] em; logic [15:0] ei; logic ee;
        logic [31:0] held;
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(0, 9));
            ops.delete();
            for (int i = 0; i < len; i++)
                ops.push_back(($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom);
            model(len, em, ei, ee);
            run_frame(len, int'($urandom_range(0, 2)), cyc, tmo);
            vectors++;
            if (tmo !== 1'b0 || bus.out_max !== em || bus.out_idx !== ei || bus.out_empty !== ee) begin
                errors++; $display("FAIL random_frame%0d len=%0d: max=%h idx=%0d empty=%b tmo=%b required %h/%0d/%b/0",
                    f, len, bus.out_max, bus.out_idx, bus.out_empty, tmo, em, ei, ee);
            end
            held = bus.out_max;
            repeat ($urandom_range(0, 3)) tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_max !== held) begin
                errors++; $display("FAIL random_hold%0d: vld=%b max=%h required 1/%h", f, bus.out_valid, bus.out_max, held);
            end
            consume();
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
                errors++; $display("FAIL random_release%0d: vld=%b cfg_rdy=%b required 0/1", f, bus.out_valid, bus.cfg_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_unsigned();
        test_done_cfg_ignored();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
